// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU:
//   - the 4-bit ALU_OP encodings (also used by the ALU control decoder)
//   - the FSM state encoding of alu_multicycle
//   - a helper that identifies the iterative shift operations
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_SUM  = 4'b0010;
  localparam logic [3:0] ALU_EQ   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_GE   = 4'b1100;
  localparam logic [3:0] ALU_GEU  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational single-cycle ALU operations: logic, add/sub and
// compares. Shift and undefined opcodes produce 0 here; shifts are executed
// iteratively by alu_multicycle.
// Ports:
//   op     : ALU_OP code
//   a, b   : operands
//   result : operation result (compares zero-extended to WIDTH)
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SUM:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_EQ:   result = WIDTH'(a == b);
      ALU_GE:   result = WIDTH'($signed(a) >= $signed(b));
      ALU_GEU:  result = WIDTH'(a >= b);
      ALU_SLT:  result = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: result = WIDTH'(a < b);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// EX-stage ALU. Single-cycle ops complete one cycle after acceptance; shifts
// move one bit per cycle, so a shift by k takes k+1 cycles.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : request, accepted only while idle (busy_o=0)
//   ALU_OP_i      : operation code
//   SRC_A_i       : operand A / shift source
//   SRC_B_i       : operand B / shift amount in [SHAMT_W-1:0]
//   busy_o        : high while an iterative shift is in progress
//   done_o        : one-cycle pulse, result/zero just updated
//   ALU_RESULT_o  : registered result, held until next done_o
//   ZERO_o        : registered (ALU_RESULT_o == 0)
// ---------------------------------------------------------------------------
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       ALU_OP_i,
  input  logic [WIDTH-1:0] SRC_A_i,
  input  logic [WIDTH-1:0] SRC_B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_RESULT_o,
  output logic             ZERO_o
);

  state_t               state_reg, state_next;
  logic [SHAMT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]     work_reg, work_next;
  logic [3:0]           op_reg, op_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 zero_reg, zero_next;
  logic                 done_reg, done_next;

  logic [WIDTH-1:0]     core_result;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     load_val;
  logic                 load_en;
  logic [SHAMT_W-1:0]   shamt;

  assign shamt = SRC_B_i[SHAMT_W-1:0];

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (ALU_OP_i),
    .a      (SRC_A_i),
    .b      (SRC_B_i),
    .result (core_result)
  );

  // One-bit step of the shift held in the work register.
  always_comb begin
    shifted = work_reg;
    case (op_reg)
      ALU_SLL: shifted = {work_reg[WIDTH-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, work_reg[WIDTH-1:1]};
      ALU_SRA: shifted = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
      default: shifted = work_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    work_next  = work_reg;
    op_next    = op_reg;
    done_next  = 1'b0;
    load_en    = 1'b0;
    load_val   = '0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (is_shift(ALU_OP_i) && (shamt != '0)) begin
            work_next  = SRC_A_i;
            op_next    = ALU_OP_i;
            cnt_next   = shamt;
            state_next = SHIFT;
          end else begin
            // A shift by zero is just the source operand.
            load_en  = 1'b1;
            load_val = is_shift(ALU_OP_i) ? SRC_A_i : core_result;
          end
        end
      end
      SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt_reg - SHAMT_W'(1);
        if (cnt_reg == SHAMT_W'(1)) begin
          load_en    = 1'b1;
          load_val   = shifted;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_en) begin
      done_next = 1'b1;
    end
    result_next = load_en ? load_val : result_reg;
    zero_next   = load_en ? (load_val == '0) : zero_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      work_reg   <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      done_reg   <= done_next;
    end
  end

  assign busy_o       = (state_reg == SHIFT);
  assign done_o       = done_reg;
  assign ALU_RESULT_o = result_reg;
  assign ZERO_o       = zero_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
// Self-checking bench for alu_multicycle (WIDTH=32). Directed scenarios plus
// randomized operations compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .ALU_OP_i     (alu_op),
    .SRC_A_i      (src_a),
    .SRC_B_i      (src_b),
    .busy_o       (busy),
    .done_o       (done),
    .ALU_RESULT_o (result),
    .ZERO_o       (zero)
  );

  // Reference model straight from the opcode table.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int k;
    k = int'(b[4:0]);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1000: return a ^ b;
      4'b1001: return ~(a | b);
      4'b0010: return a + b;
      4'b1010: return a - b;
      4'b0011: return (a == b) ? 1 : 0;
      4'b1100: return ($signed(a) >= $signed(b)) ? 1 : 0;
      4'b1101: return (a >= b) ? 1 : 0;
      4'b1110: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1111: return (a < b) ? 1 : 0;
      4'b0100: return a << k;
      4'b0101: return a >> k;
      4'b0111: return W'($signed(a) >>> k);
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b);
    if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Drives one request and waits (bounded) for done. lat=0 means timeout.
  // Inputs are scrambled after acceptance to check operand capture.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output int lat,
                        output int busy_cnt);
    @(negedge clk);
    start = 1'b1; alu_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; alu_op = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 0; busy_cnt = 0; res = '0; z = 1'b0;
    for (int c = 1; c <= W + 4; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = c; res = result; z = zero;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    logic [W-1:0] res, exp_res;
    logic         z;
    int           lat, bc, exp_lat;
    run_op(op, a, b, res, z, lat, bc);
    exp_res = ref_alu(op, a, b);
    exp_lat = ref_latency(op, b);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency op=%b a=%h b=%h got=%0d exp=%0d", name, op, a, b, lat, exp_lat);
    end
    checks++;
    if (res !== exp_res || z !== (exp_res == 0)) begin
      errors++;
      $display("FAIL %s result op=%b a=%h b=%h got=%h z=%b exp=%h z=%b",
               name, op, a, b, res, z, exp_res, exp_res == 0);
    end
    checks++;
    if (bc !== exp_lat - 1) begin
      errors++;
      $display("FAIL %s busy_cycles op=%b got=%0d exp=%0d", name, op, bc, exp_lat - 1);
    end
    $display("%s op=%b a=%h b=%h result=%h zero=%b lat=%0d", name, op, a, b, res, z, lat);
    // done must be a single-cycle pulse.
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got=%b exp=0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset busy=%b done=%b result=%h zero=%b exp 0 0 0 1", busy, done, result, zero);
    end
    $display("reset busy=%b done=%b result=%h zero=%b", busy, done, result, zero);
  endtask

  task automatic test_directed();
    check_op("sub_eq",  4'b1010, 32'd5, 32'd5);
    check_op("slt",     4'b1110, 32'hFFFF_FFFF, 32'd1);
    check_op("sltu",    4'b1111, 32'hFFFF_FFFF, 32'd1);
    check_op("sra4",    4'b0111, 32'h8000_0000, 32'd4);
    check_op("srl4",    4'b0101, 32'h8000_0000, 32'd4);
    check_op("sll0",    4'b0100, 32'h1234_5678, 32'h0000_0020);
    check_op("undef6",  4'b0110, 32'hDEAD_BEEF, 32'h1);
    check_op("undefB",  4'b1011, 32'hDEAD_BEEF, 32'h1);
    check_op("ge_neg",  4'b1100, 32'h8000_0000, 32'h7FFF_FFFF);
    check_op("geu",     4'b1101, 32'h8000_0000, 32'h7FFF_FFFF);
  endtask

  task automatic test_ignore_start();
    int n_done = 0, done_cyc = 0;
    logic [W-1:0] res = '0;
    @(negedge clk);
    start = 1'b1; alu_op = 4'b0100; src_a = 32'd1; src_b = 32'h1F;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin n_done++; done_cyc = c; res = result; end
      if (c == 10) begin
        start = 1'b1; alu_op = 4'b0010; src_a = 32'd9; src_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 1 || done_cyc !== 32 || res !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll31_ignore n_done=%0d cyc=%0d res=%h exp 1 32 80000000", n_done, done_cyc, res);
    end
    $display("sll31_ignore n_done=%0d cyc=%0d result=%h", n_done, done_cyc, res);
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [4] = '{4'b0010, 4'b1000, 4'b0011, 4'b0110};
    logic [W-1:0] as  [4] = '{32'd3, 32'hF0, 32'd7, 32'hFFFF};
    logic [W-1:0] bs  [4] = '{32'd4, 32'hFF, 32'd7, 32'hFFFF};
    logic [W-1:0] exp_r;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1; alu_op = ops[i]; src_a = as[i]; src_b = bs[i];
      @(posedge clk); #1;
      exp_r = ref_alu(ops[i], as[i], bs[i]);
      checks++;
      if (done !== 1'b1 || result !== exp_r || zero !== (exp_r == 0)) begin
        errors++;
        $display("FAIL b2b_%0d done=%b result=%h zero=%b exp 1 %h %b",
                 i, done, result, zero, exp_r, exp_r == 0);
      end
      $display("b2b_%0d op=%b result=%h done=%b", i, ops[i], result, done);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] res;
    logic         z;
    int           lat, bc, n_done;
    @(negedge clk);
    start = 1'b1; alu_op = 4'b0100; src_a = 32'd1; src_b = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    // cycles 1..3 pass, rst is raised during cycle 4
    repeat (3) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_shift busy=%b done=%b result=%h zero=%b exp 0 0 0 1",
               busy, done, result, zero);
    end
    repeat (12) begin
      if (done) n_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL rst_mid_shift_done got=%0d exp=0", n_done);
    end
    $display("rst_mid_shift busy=%b result=%h n_done=%0d", busy, result, n_done);
    run_op(4'b0010, 32'd2, 32'd2, res, z, lat, bc);
    checks++;
    if (res !== 32'd4 || lat !== 1 || z !== 1'b0) begin
      errors++;
      $display("FAIL sum_after_rst result=%h lat=%0d zero=%b exp 4 1 0", res, lat, z);
    end
    $display("sum_after_rst result=%h lat=%0d", res, lat);
  endtask

  task automatic test_reset_with_start();
    @(negedge clk);
    start = 1'b1; rst = 1'b1; alu_op = 4'b0010; src_a = 32'd1; src_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rst_with_start done=%b busy=%b result=%h exp 0 0 0", done, busy, result);
    end
    $display("rst_with_start done=%b result=%h", done, result);
  endtask

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;           // exercise equality/zero
      if ($urandom_range(0, 2) == 0) b[W-1:5] = '0;   // small operands
      check_op("rand", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    test_reset_with_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
